// File: rtl/ram8.sv
// -----------------------------------------------------------------------------
// ram8 -- small register-file RAM, 2^ADDR_W words of DATA_W bits.
//
// Storage is one flip-flop register per word. A load decoder turns
// (load, address) into a one-hot write strobe. An output multiplexer selects
// the addressed word.
//
// Reads are purely combinational. Writes land on the rising clock edge.
// A read of the address being written therefore shows the old word until the
// edge and the new word after it; there is no write-through path.
//
// Ports
//   clk      in   1        single clock, all state changes on rising edge
//   reset    in   1        synchronous active-high clear of every word
//   address  in   ADDR_W   word select for both read and write
//   in       in   DATA_W   write data
//   load     in   1        write enable, active-high
//   out      out  DATA_W   contents of word[address], zero latency
//
// Handshake: none. A write is accepted on every rising edge where load=1 and
// reset=0. A read is valid whenever address is stable.
// -----------------------------------------------------------------------------
module ram8 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    output logic [DATA_W-1:0] out
);

    localparam int DEPTH = 1 << ADDR_W;

    // One independent register per word.
    logic [DATA_W-1:0] r_words [DEPTH];

    // One-hot write strobe per word.
    logic [DEPTH-1:0]  w_load_dec;

    // Load decoder (demux). The address covers the full depth, so every
    // address value selects exactly one distinct word.
    always_comb begin
        w_load_dec = '0;
        if (load) begin
            w_load_dec[address] = 1'b1;
        end
    end

    // Word registers. Reset is checked first, so a write that coincides with
    // reset is discarded.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                r_words[i] <= '0;
            end else if (w_load_dec[i]) begin
                r_words[i] <= in;
            end
        end
    end

    // Output multiplexer. This is a combinational read that follows address
    // immediately.
    assign out = r_words[address];

endmodule

// File: tb/tb_ram8.sv
// -----------------------------------------------------------------------------
// tb_ram8 -- self-checking bench for ram8.
//
// The reference model is a plain array of words. At each clock edge it is
// updated from the inputs that were sampled there. Every read of the DUT is
// compared against the model entry for the current address.
// -----------------------------------------------------------------------------
module tb_ram8;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] in;
    logic              load;
    logic [DATA_W-1:0] out;

    // Reference model: the expected contents of each word.
    logic [DATA_W-1:0] model_mem [DEPTH];

    // Expected read values waiting to be compared.
    logic [DATA_W-1:0] exp_q [$];

    int total;
    int bad;

    ram8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .in      (in),
        .load    (load),
        .out     (out)
    );

    // ---------------- clock ----------------
    // The period is long so that many #1-spaced reads fit between edges.
    initial clk = 1'b0;
    always #50 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Set address, let the combinational read settle, then compare against the
    // model through the expected queue.
    task automatic read_check(input string tag, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] e;
        address = a;
        exp_q.push_back(model_mem[a]);
        #1;
        e = exp_q.pop_front();
        check_val(tag, out, e);
    endtask

    // Capture the inputs that the upcoming edge sees, then wait for that edge.
    // Apply the same rules to the model: reset clears everything, otherwise
    // load writes only the addressed word.
    task automatic clock_edge();
        logic              s_rst;
        logic              s_ld;
        logic [ADDR_W-1:0] s_a;
        logic [DATA_W-1:0] s_d;
        @(posedge clk);
        s_rst = reset;
        s_ld  = load;
        s_a   = address;
        s_d   = in;
        #1;
        if (s_rst) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        end else if (s_ld) begin
            model_mem[s_a] = s_d;
        end
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        clock_edge();
        load    = 1'b0;
    endtask

    task automatic sweep_all(input string tag);
        for (int i = 0; i < DEPTH; i++) read_check(tag, ADDR_W'(i));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        load    = 1'b0;
        address = '0;
        in      = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

        // Reset, then read back zero at every address.
        #3;
        reset = 1'b1;
        clock_edge();
        reset = 1'b0;
        sweep_all("reset_sweep");

        // Write and overwrite address 0.
        write_word(3'd0, 16'h3524);
        check_val("wr0_first", out, 16'h3524);
        write_word(3'd0, 16'h0000);
        check_val("wr0_zero", out, 16'h0000);
        write_word(3'd0, 16'h5E81);
        check_val("wr0_second", out, 16'h5E81);

        // Isolation between words.
        write_word(3'd7, 16'h0D09);
        write_word(3'd3, 16'hFFFF);
        address = 3'd0; #1; check_val("iso_a0", out, 16'h5E81);
        address = 3'd3; #1; check_val("iso_a3", out, 16'hFFFF);
        address = 3'd7; #1; check_val("iso_a7", out, 16'h0D09);
        sweep_all("iso_sweep");

        // Hold: load low, in changing, several edges.
        address = 3'd7;
        in      = 16'h1234;
        load    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            clock_edge();
            check_val("hold_a7", out, 16'h0D09);
        end
        sweep_all("hold_sweep");

        // Read during write: the old value shows before the edge, the new one after.
        address = 3'd3;
        in      = 16'h4242;
        load    = 1'b1;
        #1;
        check_val("rdw_before", out, 16'hFFFF);
        clock_edge();
        load = 1'b0;
        check_val("rdw_after", out, 16'h4242);

        // Back-to-back writes to the same address: the last write wins.
        address = 3'd5;
        load    = 1'b1;
        in      = 16'h1111; clock_edge();
        in      = 16'h2222; clock_edge();
        in      = 16'h3333; clock_edge();
        load    = 1'b0;
        check_val("b2b_last", out, 16'h3333);
        sweep_all("b2b_sweep");

        // Glitches on in, load and reset between edges must not alter any word.
        address = 3'd1;
        load = 1'b1; in = 16'hDEAD; #2;
        reset = 1'b1; #2; reset = 1'b0;
        in = 16'hBEEF; #2; load = 1'b0; #2;
        clock_edge();
        sweep_all("glitch_sweep");

        // Combinational read: address changes with no clock edge in between.
        address = 3'd7; #1; check_val("comb_a7", out, 16'h0D09);
        address = 3'd0; #1; check_val("comb_a0", out, 16'h5E81);
        address = 3'd3; #1; check_val("comb_a3", out, 16'h4242);

        // Reset priority over a coincident write.
        reset   = 1'b1;
        load    = 1'b1;
        address = 3'd3;
        in      = 16'hAAAA;
        clock_edge();
        reset   = 1'b0;
        load    = 1'b0;
        check_val("rst_prio_a3", out, 16'h0000);
        sweep_all("rst_prio_sweep");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            address = ADDR_W'($urandom_range(0, DEPTH - 1));
            in      = DATA_W'($urandom);
            load    = ($urandom_range(0, 99) < 60);
            reset   = ($urandom_range(0, 99) < 3);
            // Pre-edge read of the target word: the write has not landed yet.
            read_check("rnd_pre", address);
            clock_edge();
            reset = 1'b0;
            load  = 1'b0;
            read_check("rnd_post", address);
            read_check("rnd_other", ADDR_W'($urandom_range(0, DEPTH - 1)));
        end
        sweep_all("final_sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #10_000_000;
        bad++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram8.md
RAM8 -- requirements
Module: ram8

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, which sets the word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 3, which sets the address width; depth is 2^ADDR_W words (8 by default).
REQ-003 The module SHALL have port `clk`, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port `reset`, input, 1 bit: synchronous, active-high clear.
REQ-005 The module SHALL have port `address`, input, ADDR_W bits: selects the word to read and to write.
REQ-006 The module SHALL have port `in`, input, DATA_W bits: write data.
REQ-007 The module SHALL have port `load`, input, 1 bit: write enable, active-high.
REQ-008 The module SHALL have port `out`, output, DATA_W bits: read data of the addressed word.
REQ-009 The design SHALL use one clock `clk`, with a synchronous, active-high reset named `reset`.

Function
REQ-010 Storage SHALL be 2^ADDR_W independent registers of DATA_W bits each.
- Structure: one register per word, a load decoder (demux) and an output multiplexer.
- No inferred memory macro is required.
REQ-011 Read SHALL be combinational, with zero-cycle latency.
- `out` equals word[address] at all times.
- `out` follows any change of `address` without waiting for a clock edge.
REQ-012 Write SHALL happen on the rising edge of `clk` when `load`=1 and `reset`=0.
- The edge sets word[address] = `in`.
- No other word changes.
REQ-013 When `load`=0 and `reset`=0, all words SHALL hold their values across clock edges.
REQ-014 Read-during-write to the same address SHALL behave as follows:
- Before the edge, `out` shows the old value.
- After the edge, `out` shows the newly written value.
- There is no write-through before the edge.
REQ-015 Changes on `in` or `load` between edges SHALL NOT alter stored contents.
REQ-016 Back-to-back writes to the same address on consecutive edges SHALL each take effect; the last write wins.
REQ-017 Address SHALL cover the full range with no wrap or out-of-range case: every value 0..2^ADDR_W-1 maps to a distinct word.
REQ-018 Undefined (X/Z) inputs are outside the required behaviour; no X-propagation guarantees are made.

Reset
REQ-019 On a rising edge with `reset`=1, all words SHALL be cleared to 0, irrespective of `load`, `address` and `in`.
REQ-020 `reset` SHALL have priority over `load`: a write coincident with reset is discarded.
REQ-021 After the reset edge, `out` SHALL read 0 for every address until a subsequent write.
REQ-022 Reset asserted between edges SHALL have no effect until the next rising edge; it is strictly synchronous.
REQ-023 Power-up contents before the first reset are unspecified; a bench SHALL apply reset before checking values.

Verification
REQ-024 Reset then read: assert `reset` for 1 edge, then sweep `address` 0..7 with `load`=0 -> `out`=0 at every address.
REQ-025 Write/overwrite one address:
- `address`=0, `in`=16'h3524, `load`=1, one edge -> `out`=16'h3524.
- Next edge with `in`=0 -> `out`=0.
- Next edge with `in`=16'h5E81 -> `out`=16'h5E81.
REQ-026 Isolation:
- Write 16'h0D09 to address 7 and 16'hFFFF to address 3.
- Read addresses 0, 3 and 7 -> 16'h5E81, 16'hFFFF and 16'h0D09 respectively.
- All other words unchanged.
REQ-027 Hold: with `load`=0, `address`=7 and `in`=16'h1234, apply several edges -> `out` stays 16'h0D09 and no word changes.
REQ-028 Reset priority: `reset`=1, `load`=1, `address`=3, `in`=16'hAAAA, one edge -> all eight words read 0, including address 3.
REQ-029 Combinational read: change `address` between edges with no clock edge -> `out` updates immediately to the newly addressed word.
